// File: rtl/vst_pkg.sv
// Shared types and constants for the vector-display sequencer.
package vst_pkg;

   // Default coordinate / DAC value width.
   localparam int BITS_DEF = 12;

   // DAC channel select encoding on dac_axis.
   localparam logic AXIS_X = 1'b1;
   localparam logic AXIS_Y = 1'b0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARM,
      ST_CHECK,
      ST_SEND_X,
      ST_WAIT_X,
      ST_SEND_Y,
      ST_WAIT_Y,
      ST_STEP,
      ST_SETTLE
   } state_t;

endpackage

// File: rtl/vector_sequencer.sv
// vector_sequencer: accepts draw/move commands, loads the line engine, walks it
// one point at a time and sends each point to the SPI DAC as X then Y, skipping
// a channel whose value has not changed since its last write.
module vector_sequencer
   import vst_pkg::*;
#(
   parameter int BITS   = BITS_DEF,
   parameter int SETTLE = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [BITS-1:0] cmd_x,
   input  logic [BITS-1:0] cmd_y,
   input  logic            cmd_move,
   output logic            line_strobe,
   output logic [BITS-1:0] line_x,
   output logic [BITS-1:0] line_y,
   output logic            line_step,
   input  logic            line_ready,
   input  logic [BITS-1:0] line_x_pos,
   input  logic [BITS-1:0] line_y_pos,
   output logic            dac_strobe,
   output logic [BITS-1:0] dac_value,
   output logic            dac_axis,
   input  logic            dac_ready,
   output logic            blank,
   output logic            busy
);

   localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

   state_t            state_q, state_d;
   logic [BITS-1:0]   line_x_q, line_x_d;
   logic [BITS-1:0]   line_y_q, line_y_d;
   logic              move_q, move_d;
   logic              blank_q, blank_d;
   logic [BITS-1:0]   pt_x_q, pt_x_d;
   logic [BITS-1:0]   pt_y_q, pt_y_d;
   logic [BITS-1:0]   dac_value_q, dac_value_d;
   logic              dac_axis_q, dac_axis_d;
   // High only on the first cycle of WAIT_X/WAIT_Y: doubles as the DAC strobe
   // and as the "DAC has not seen the strobe yet, ignore dac_ready" flag.
   logic              dac_strobe_q, dac_strobe_d;
   logic [BITS-1:0]   last_x_q, last_x_d;
   logic [BITS-1:0]   last_y_q, last_y_d;
   logic              last_x_vld_q, last_x_vld_d;
   logic              last_y_vld_q, last_y_vld_d;
   logic [CW-1:0]     settle_q, settle_d;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers; last-written values become invalid on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_x_q     <= '0;
         line_y_q     <= '0;
         move_q       <= 1'b0;
         blank_q      <= 1'b1;
         pt_x_q       <= '0;
         pt_y_q       <= '0;
         dac_value_q  <= '0;
         dac_axis_q   <= AXIS_Y;
         dac_strobe_q <= 1'b0;
         last_x_q     <= '0;
         last_y_q     <= '0;
         last_x_vld_q <= 1'b0;
         last_y_vld_q <= 1'b0;
         settle_q     <= '0;
      end else begin
         line_x_q     <= line_x_d;
         line_y_q     <= line_y_d;
         move_q       <= move_d;
         blank_q      <= blank_d;
         pt_x_q       <= pt_x_d;
         pt_y_q       <= pt_y_d;
         dac_value_q  <= dac_value_d;
         dac_axis_q   <= dac_axis_d;
         dac_strobe_q <= dac_strobe_d;
         last_x_q     <= last_x_d;
         last_y_q     <= last_y_d;
         last_x_vld_q <= last_x_vld_d;
         last_y_vld_q <= last_y_vld_d;
         settle_q     <= settle_d;
      end
   end

   // Next-state and datapath update for the command / point / DAC sequence.
   always_comb begin
      state_d      = state_q;
      line_x_d     = line_x_q;
      line_y_d     = line_y_q;
      move_d       = move_q;
      blank_d      = blank_q;
      pt_x_d       = pt_x_q;
      pt_y_d       = pt_y_q;
      dac_value_d  = dac_value_q;
      dac_axis_d   = dac_axis_q;
      dac_strobe_d = 1'b0;
      last_x_d     = last_x_q;
      last_y_d     = last_y_q;
      last_x_vld_d = last_x_vld_q;
      last_y_vld_d = last_y_vld_q;
      settle_d     = settle_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               line_x_d = cmd_x;
               line_y_d = cmd_y;
               move_d   = cmd_move;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            blank_d = move_q;
            state_d = ST_ARM;
         end
         // Engine outputs may still reflect the previous target here.
         ST_ARM: state_d = ST_CHECK;
         ST_CHECK: begin
            // A move shows the target directly; a draw shows the engine position.
            pt_x_d  = move_q ? line_x_q : line_x_pos;
            pt_y_d  = move_q ? line_y_q : line_y_pos;
            state_d = ST_SEND_X;
         end
         ST_SEND_X: begin
            if (last_x_vld_q && (pt_x_q == last_x_q)) begin
               state_d = ST_SEND_Y;
            end else if (dac_ready) begin
               dac_strobe_d = 1'b1;
               dac_value_d  = pt_x_q;
               dac_axis_d   = AXIS_X;
               last_x_d     = pt_x_q;
               last_x_vld_d = 1'b1;
               state_d      = ST_WAIT_X;
            end
         end
         ST_WAIT_X: begin
            if (!dac_strobe_q && dac_ready) state_d = ST_SEND_Y;
         end
         ST_SEND_Y: begin
            if (last_y_vld_q && (pt_y_q == last_y_q)) begin
               state_d = ST_STEP;
            end else if (dac_ready) begin
               dac_strobe_d = 1'b1;
               dac_value_d  = pt_y_q;
               dac_axis_d   = AXIS_Y;
               last_y_d     = pt_y_q;
               last_y_vld_d = 1'b1;
               state_d      = ST_WAIT_Y;
            end
         end
         ST_WAIT_Y: begin
            if (!dac_strobe_q && dac_ready) state_d = ST_STEP;
         end
         ST_STEP: begin
            if (move_q) begin
               if (SETTLE > 0) begin
                  settle_d = SETTLE_LOAD;
                  state_d  = ST_SETTLE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (line_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_SETTLE: begin
            if (settle_q == '0) state_d = ST_IDLE;
            else                settle_d = settle_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Decoded outputs; the second strobe on a move parks the engine on its target.
   always_comb begin
      cmd_ready   = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      line_strobe = (state_q == ST_LOAD) || ((state_q == ST_STEP) && move_q);
      line_step   = (state_q == ST_STEP) && !move_q && !line_ready;
   end

   assign line_x     = line_x_q;
   assign line_y     = line_y_q;
   assign dac_strobe = dac_strobe_q;
   assign dac_value  = dac_value_q;
   assign dac_axis   = dac_axis_q;
   assign blank      = blank_q;

endmodule
